// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default oversampling and FSM state encodings
// for both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS          = 8;
  localparam int unsigned UART_OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_STOP    = 3'd3,
    RX_RECOVER = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line in, recovered byte and status strobes out.
interface uart_rx_if;
  import uart_pkg::*;

  logic                      rx;
  logic [UART_DATA_BITS-1:0] data_out;
  logic                      rx_done;
  logic                      frame_err;
  logic                      busy;

  modport master (input rx, output data_out, rx_done, frame_err, busy);
  modport slave  (output rx, input data_out, rx_done, frame_err, busy);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level; resets to 1 so an idle-high line
// does not look active out of reset.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on an oversampled baud clock: centre-samples each bit, strobes
// rx_done on a good frame and frame_err on a low stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
  input  logic      baud_clk,
  input  logic      reset_n,
  uart_rx_if.master bus
);

  localparam int unsigned DW     = UART_DATA_BITS;
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DW - 1);

  logic rx_s;

  rx_state_e         state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_q, bit_d;
  logic [DW-1:0]     shreg_q, shreg_d;
  logic [DW-1:0]     data_q, data_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;

  uart_sync2 u_sync (
    .clk   (baud_clk),
    .rst_n (reset_n),
    .d     (bus.rx),
    .q     (rx_s)
  );

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, counters and strobes; strobes are single-cycle by defaulting to 0.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          tick_d  = '0;
        end
      end
      RX_START: begin
        if (tick_q == TICK_HALF) begin
          tick_d = '0;
          if (!rx_s) begin
            state_d = RX_DATA;
            bit_d   = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      RX_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shreg_d = {rx_s, shreg_q[DW-1:1]};
          if (bit_q == BIT_LAST) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      RX_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (rx_s) begin
            data_d  = shreg_q;
            done_d  = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_RECOVER;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      // Hold off until the line releases so a break is not decoded as 0x00 frames.
      RX_RECOVER: begin
        if (rx_s) begin
          state_d = RX_IDLE;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase

    busy_d = (state_d != RX_IDLE);
  end

  assign bus.data_out  = data_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16x oversampling: frame timing, back-to-back, glitch,
// framing error/recovery, mid-frame reset and a 256-byte serial stream.
module tb_uart_rx;

  logic baud_clk;
  logic reset_n;
  int   cyc;
  int   passed;
  int   total;
  int   both_hi;

  int         done_cyc_q[$];
  logic [7:0] done_dat_q[$];
  int         ferr_cyc_q[$];

  uart_rx_if u_if ();

  uart_rx #(.OVERSAMPLE(16)) dut (
    .baud_clk (baud_clk),
    .reset_n  (reset_n),
    .bus      (u_if.master)
  );

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  always @(posedge baud_clk) cyc = cyc + 1;

  // Strobe log, sampled on the falling edge
  always @(negedge baud_clk) begin
    if (u_if.rx_done) begin
      done_cyc_q.push_back(cyc);
      done_dat_q.push_back(u_if.data_out);
    end
    if (u_if.frame_err) ferr_cyc_q.push_back(cyc);
    if (u_if.rx_done && u_if.frame_err) both_hi = both_hi + 1;
  end

  task automatic clear_log();
    done_cyc_q.delete();
    done_dat_q.delete();
    ferr_cyc_q.delete();
  endtask

  // Called on a falling edge; k is the first rising edge that sees the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int k);
    u_if.rx = 1'b0;
    k = cyc + 1;
    repeat (16) @(negedge baud_clk);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = b[i];
      repeat (16) @(negedge baud_clk);
    end
    u_if.rx = stop_bit;
    repeat (16) @(negedge baud_clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    u_if.rx = 1'b1;
    repeat (3) @(negedge baud_clk);
    total++; if (u_if.data_out !== 8'h00) $display("FAIL reset_data_out got=%h exp=00", u_if.data_out); else passed++;
    total++; if (u_if.rx_done !== 1'b0) $display("FAIL reset_rx_done got=%b exp=0", u_if.rx_done); else passed++;
    total++; if (u_if.frame_err !== 1'b0) $display("FAIL reset_frame_err got=%b exp=0", u_if.frame_err); else passed++;
    total++; if (u_if.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", u_if.busy); else passed++;
    reset_n = 1'b1;
    repeat (4) @(negedge baud_clk);
  endtask

  task automatic test_single_frame();
    int k;
    clear_log();
    send_frame(8'hA5, 1'b1, k);
    total++; if (done_cyc_q.size() !== 1) $display("FAIL single_done_count got=%0d exp=1", done_cyc_q.size()); else passed++;
    if (done_cyc_q.size() > 0) begin
      total++; if (done_cyc_q[0] !== k + 154) $display("FAIL single_done_cycle got=%0d exp=%0d", done_cyc_q[0], k + 154); else passed++;
      total++; if (done_dat_q[0] !== 8'hA5) $display("FAIL single_data got=%h exp=a5", done_dat_q[0]); else passed++;
    end
    total++; if (ferr_cyc_q.size() !== 0) $display("FAIL single_frame_err got=%0d exp=0", ferr_cyc_q.size()); else passed++;
    total++; if (u_if.data_out !== 8'hA5) $display("FAIL single_data_hold got=%h exp=a5", u_if.data_out); else passed++;
    total++; if (u_if.busy !== 1'b0) $display("FAIL single_busy_idle got=%b exp=0", u_if.busy); else passed++;
  endtask

  task automatic test_back_to_back();
    int k0, k1;
    clear_log();
    send_frame(8'h00, 1'b1, k0);
    send_frame(8'hFF, 1'b1, k1);
    total++; if (done_cyc_q.size() !== 2) $display("FAIL b2b_done_count got=%0d exp=2", done_cyc_q.size()); else passed++;
    if (done_cyc_q.size() == 2) begin
      total++; if (done_cyc_q[0] !== k0 + 154) $display("FAIL b2b_first_cycle got=%0d exp=%0d", done_cyc_q[0], k0 + 154); else passed++;
      total++; if (done_cyc_q[1] - done_cyc_q[0] !== 160) $display("FAIL b2b_spacing got=%0d exp=160", done_cyc_q[1] - done_cyc_q[0]); else passed++;
      total++; if (done_dat_q[0] !== 8'h00) $display("FAIL b2b_data0 got=%h exp=00", done_dat_q[0]); else passed++;
      total++; if (done_dat_q[1] !== 8'hFF) $display("FAIL b2b_data1 got=%h exp=ff", done_dat_q[1]); else passed++;
    end
    total++; if (ferr_cyc_q.size() !== 0) $display("FAIL b2b_frame_err got=%0d exp=0", ferr_cyc_q.size()); else passed++;
  endtask

  task automatic test_glitch();
    logic saw_busy;
    clear_log();
    saw_busy = 1'b0;
    u_if.rx = 1'b0;
    repeat (4) @(negedge baud_clk);
    u_if.rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge baud_clk);
      if (u_if.busy) saw_busy = 1'b1;
    end
    total++; if (saw_busy !== 1'b1) $display("FAIL glitch_busy_seen got=%b exp=1", saw_busy); else passed++;
    total++; if (u_if.busy !== 1'b0) $display("FAIL glitch_back_idle got=%b exp=0", u_if.busy); else passed++;
    total++; if (done_cyc_q.size() + ferr_cyc_q.size() !== 0) $display("FAIL glitch_strobes got=%0d exp=0", done_cyc_q.size() + ferr_cyc_q.size()); else passed++;
    total++; if (u_if.data_out !== 8'hFF) $display("FAIL glitch_data_hold got=%h exp=ff", u_if.data_out); else passed++;
  endtask

  task automatic test_framing_error();
    int k;
    clear_log();
    send_frame(8'h3C, 1'b0, k);
    repeat (40) @(negedge baud_clk);
    total++; if (ferr_cyc_q.size() !== 1) $display("FAIL ferr_count got=%0d exp=1", ferr_cyc_q.size()); else passed++;
    if (ferr_cyc_q.size() > 0) begin
      total++; if (ferr_cyc_q[0] !== k + 154) $display("FAIL ferr_cycle got=%0d exp=%0d", ferr_cyc_q[0], k + 154); else passed++;
    end
    total++; if (done_cyc_q.size() !== 0) $display("FAIL ferr_no_done got=%0d exp=0", done_cyc_q.size()); else passed++;
    total++; if (u_if.data_out !== 8'hFF) $display("FAIL ferr_data_hold got=%h exp=ff", u_if.data_out); else passed++;
    total++; if (u_if.busy !== 1'b1) $display("FAIL ferr_busy_low_line got=%b exp=1", u_if.busy); else passed++;
    u_if.rx = 1'b1;
    repeat (2) @(negedge baud_clk);
    total++; if (u_if.busy !== 1'b1) $display("FAIL ferr_busy_until_sync got=%b exp=1", u_if.busy); else passed++;
    @(negedge baud_clk);
    total++; if (u_if.busy !== 1'b0) $display("FAIL ferr_busy_release got=%b exp=0", u_if.busy); else passed++;
    repeat (5) @(negedge baud_clk);
    clear_log();
    send_frame(8'h5A, 1'b1, k);
    total++; if (done_dat_q.size() !== 1) $display("FAIL ferr_next_count got=%0d exp=1", done_dat_q.size()); else passed++;
    if (done_dat_q.size() > 0) begin
      total++; if (done_dat_q[0] !== 8'h5A) $display("FAIL ferr_next_data got=%h exp=5a", done_dat_q[0]); else passed++;
    end
    total++; if (ferr_cyc_q.size() !== 0) $display("FAIL ferr_next_no_err got=%0d exp=0", ferr_cyc_q.size()); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int k;
    logic [7:0] b;
    clear_log();
    b = 8'hC3;
    u_if.rx = 1'b0;
    repeat (16) @(negedge baud_clk);
    for (int i = 0; i < 3; i++) begin
      u_if.rx = b[i];
      repeat (16) @(negedge baud_clk);
    end
    u_if.rx = b[3];
    repeat (8) @(negedge baud_clk);
    total++; if (u_if.busy !== 1'b1) $display("FAIL rst_mid_busy_before got=%b exp=1", u_if.busy); else passed++;
    reset_n = 1'b0;
    #1;
    total++; if (u_if.data_out !== 8'h00) $display("FAIL rst_mid_data got=%h exp=00", u_if.data_out); else passed++;
    total++; if (u_if.busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", u_if.busy); else passed++;
    total++; if (u_if.rx_done !== 1'b0 || u_if.frame_err !== 1'b0) $display("FAIL rst_mid_strobes got=%b%b exp=00", u_if.rx_done, u_if.frame_err); else passed++;
    u_if.rx = 1'b1;
    repeat (3) @(negedge baud_clk);
    reset_n = 1'b1;
    repeat (5) @(negedge baud_clk);
    total++; if (done_cyc_q.size() + ferr_cyc_q.size() !== 0) $display("FAIL rst_mid_no_strobe got=%0d exp=0", done_cyc_q.size() + ferr_cyc_q.size()); else passed++;
    send_frame(8'h81, 1'b1, k);
    total++; if (done_dat_q.size() !== 1) $display("FAIL rst_mid_next_count got=%0d exp=1", done_dat_q.size()); else passed++;
    if (done_dat_q.size() > 0) begin
      total++; if (done_dat_q[0] !== 8'h81) $display("FAIL rst_mid_next_data got=%h exp=81", done_dat_q[0]); else passed++;
      total++; if (done_cyc_q[0] !== k + 154) $display("FAIL rst_mid_next_cycle got=%0d exp=%0d", done_cyc_q[0], k + 154); else passed++;
    end
  endtask

  task automatic test_loopback();
    int k;
    logic [7:0] b;
    clear_log();
    for (int n = 0; n < 256; n++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, k);
      total++;
      if (done_dat_q.size() !== n + 1) $display("FAIL loop_count n=%0d got=%0d exp=%0d", n, done_dat_q.size(), n + 1);
      else if (done_dat_q[n] !== b) $display("FAIL loop_data n=%0d got=%h exp=%h", n, done_dat_q[n], b);
      else passed++;
      repeat ($urandom_range(0, 3)) @(negedge baud_clk);
    end
    total++; if (ferr_cyc_q.size() !== 0) $display("FAIL loop_frame_err got=%0d exp=0", ferr_cyc_q.size()); else passed++;
    total++; if (both_hi !== 0) $display("FAIL strobes_exclusive got=%0d exp=0", both_hi); else passed++;
  endtask

  initial begin
    cyc     = 0;
    passed  = 0;
    total   = 0;
    both_hi = 0;
    u_if.rx = 1'b1;
    @(negedge baud_clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    test_loopback();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
